conv_enc_block_sched: RTL and testbench
=======================================

Name: conv_enc_block_sched

Overview:
Block-level scheduler for the convolutional encoder datapath. It waits for a block to be announced, pops one meta byte to get the block size, then streams that block's data bytes from the input data FIFO into the encoder core. It throttles on input-FIFO empty and output-FIFO almost-full, waits for the encoder's completion pulse, and re-arms. It sits between the two input FIFOs (data, meta) and the encoder core, and replaces the encoder's direct FIFO read strobes.

Parameters:
SMALL_BYTES, 132, byte count of a small block (1056 bits)
LARGE_BYTES, 768, byte count of a large block (6144 bits)
DONE_TIMEOUT, 4095, cycles to wait for enc_done after the last byte before flagging an error

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
blk_ready  in  1  level; a complete block is present in the FIFOs
meta_empty  in  1  meta FIFO empty flag
meta_q  in  8  meta FIFO output; valid 1 cycle after meta_rdreq (non-show-ahead)
meta_rdreq  out  1  meta FIFO pop strobe
data_empty  in  1  data FIFO empty flag
data_q  in  8  data FIFO output; valid 1 cycle after data_rdreq
data_rdreq  out  1  data FIFO pop strobe
out_afull  in  1  OR of the three output FIFO almost-full flags
enc_start  out  1  one-cycle pulse; encoder begins a new block
enc_size  out  1  registered block size to encoder (0 = small, 1 = large)
enc_byte  out  8  byte to encoder
enc_byte_valid  out  1  enc_byte is valid this cycle
enc_done  in  1  encoder pulse; the last coded bits of the block have been written
busy  out  1  high from meta pop to the cycle after enc_done
byte_count  out  10  bytes issued in the current block
blk_count  out  16  blocks completed since reset; wraps at 65535 -> 0
err_timeout  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; enc_byte = 8'h00.
- States: IDLE, META_RD, META_LAT, START, FEED, WAIT_DONE.
- IDLE: go to META_RD when blk_ready && !meta_empty.
- META_RD: meta_rdreq = 1 for exactly 1 cycle; busy goes to 1.
- META_LAT: latch enc_size = meta_q[0] and target = enc_size ? LARGE_BYTES : SMALL_BYTES. meta_q[7:1] is ignored.
- START: enc_start = 1 for 1 cycle; byte_count cleared to 0.
- FEED:
  - data_rdreq = !data_empty && !out_afull && (issued < target).
  - "issued" counts rdreq strobes. byte_count counts valid bytes delivered.
  - enc_byte_valid is data_rdreq delayed 1 cycle. enc_byte is data_q captured on that cycle.
  - Throughput is 1 byte/cycle when not throttled.
- Throttling:
  - data_empty or out_afull deasserts data_rdreq in the same cycle (combinational gate).
  - Any byte already requested is still delivered one cycle later.
- FEED -> WAIT_DONE: on the cycle the target-th enc_byte_valid is asserted.
- WAIT_DONE:
  - No FIFO reads.
  - On enc_done: blk_count increments, busy drops next cycle, state returns to IDLE.
  - If DONE_TIMEOUT cycles pass without enc_done: set err_timeout and return to IDLE. blk_count does not increment.
- enc_done seen in any state other than WAIT_DONE: ignored.
- Back-to-back blocks: IDLE re-evaluates on the cycle after returning. Minimum gap between a block's last byte and the next enc_start is 4 cycles plus the enc_done wait.
- blk_ready dropping mid-block: no effect; the block runs to completion.
- Data FIFO underrun: a stall in FEED is unbounded. No timeout applies in FEED.
- Reset mid-block: the block is abandoned and all counters clear. FIFO contents are not flushed; that is the system's responsibility.
- Counter widths: issued and byte_count are 10 bits, sufficient for 768. blk_count is 16 bits, wrapping.

Test Plan:
1. Small block, no stalls. meta_q = 8'h00 and 132 data bytes 0..131 queued, blk_ready = 1.
   -> one meta_rdreq; enc_start 3 cycles after leaving IDLE; enc_size = 0.
   -> 132 consecutive enc_byte_valid with enc_byte = 0..131.
   -> enc_done in WAIT_DONE gives blk_count = 1 and busy = 0.
2. Large block with throttle. meta = 8'h01 and 768 bytes queued; out_afull held high for 10 cycles starting at byte 100.
   -> exactly 768 valid bytes in order.
   -> no data_rdreq while out_afull = 1.
   -> byte_count = 768 at the WAIT_DONE transition.
3. Data underrun. Small block with only 50 bytes initially; the remaining 82 bytes arrive 200 cycles later.
   -> the scheduler stalls in FEED with no data_rdreq on data_empty, then resumes.
   -> 132 bytes total; no err_timeout.
4. Timeout. enc_done is never asserted after the final byte.
   -> err_timeout = 1 after DONE_TIMEOUT cycles; state returns to IDLE; blk_count unchanged.
   -> err_timeout stays 1 across later blocks until reset.
5. Reset mid-FEED. Assert reset at byte 60 of a large block.
   -> all outputs 0 immediately, asynchronously.
   -> after release, a fresh block is processed correctly from its meta pop.
6. Back-to-back and stray done. Two queued blocks (small then large); inject an enc_done pulse during FEED of block 1.
   -> the stray pulse is ignored.
   -> two enc_start pulses with enc_size 0 then 1; final blk_count = 2.

Source files
------------

// File: rtl/conv_enc_block_sched.sv
// rtl/conv_enc_block_sched.sv - block scheduler feeding the convolutional encoder core
// Pops one meta byte per block, streams that block's data bytes under FIFO/afull throttle, then awaits enc_done.
module conv_enc_block_sched #(
  parameter int SMALL_BYTES  = 132,
  parameter int LARGE_BYTES  = 768,
  parameter int DONE_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        blk_ready,
  input  logic        meta_empty,
  input  logic [7:0]  meta_q,
  output logic        meta_rdreq,
  input  logic        data_empty,
  input  logic [7:0]  data_q,
  output logic        data_rdreq,
  input  logic        out_afull,
  output logic        enc_start,
  output logic        enc_size,
  output logic [7:0]  enc_byte,
  output logic        enc_byte_valid,
  input  logic        enc_done,
  output logic        busy,
  output logic [9:0]  byte_count,
  output logic [15:0] blk_count,
  output logic        err_timeout
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, META_RD, META_LAT, START, FEED, WAIT_DONE
  } state_t;

  state_t        state, state_nx;
  logic [9:0]    target;
  logic [9:0]    issued;
  logic [TW-1:0] wait_cnt;
  logic          last_byte;
  logic          timeout_hit;

  assign last_byte   = enc_byte_valid && (byte_count == target - 10'd1);
  assign timeout_hit = (wait_cnt == TW'(DONE_TIMEOUT - 1));
  assign busy        = (state != IDLE);
  // Non-show-ahead FIFO: data_q is valid exactly on the cycle after the pop.
  assign enc_byte    = enc_byte_valid ? data_q : 8'h00;

  always_comb begin
    state_nx   = state;
    meta_rdreq = 1'b0;
    enc_start  = 1'b0;
    data_rdreq = 1'b0;
    case (state)
      IDLE:      if (blk_ready && !meta_empty) state_nx = META_RD;
      META_RD: begin
        meta_rdreq = 1'b1;
        state_nx   = META_LAT;
      end
      META_LAT:  state_nx = START;
      START: begin
        enc_start = 1'b1;
        state_nx  = FEED;
      end
      FEED: begin
        data_rdreq = !data_empty && !out_afull && (issued < target);
        if (last_byte) state_nx = WAIT_DONE;
      end
      WAIT_DONE: if (enc_done || timeout_hit) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      enc_size       <= 1'b0;
      target         <= 10'd0;
      issued         <= 10'd0;
      byte_count     <= 10'd0;
      blk_count      <= 16'd0;
      err_timeout    <= 1'b0;
      wait_cnt       <= '0;
      enc_byte_valid <= 1'b0;
    end else begin
      state          <= state_nx;
      enc_byte_valid <= data_rdreq;
      if (state == META_LAT) begin
        enc_size <= meta_q[0];
        target   <= meta_q[0] ? 10'(LARGE_BYTES) : 10'(SMALL_BYTES);
      end
      if (state == START) begin
        issued     <= 10'd0;
        byte_count <= 10'd0;
      end else begin
        if (data_rdreq)     issued     <= issued + 10'd1;
        if (enc_byte_valid) byte_count <= byte_count + 10'd1;
      end
      // Timeout counter only runs while waiting for the encoder to finish.
      if (state == WAIT_DONE) wait_cnt <= wait_cnt + 1'b1;
      else                    wait_cnt <= '0;
      if (state == WAIT_DONE) begin
        if (enc_done)         blk_count   <= blk_count + 16'd1;
        else if (timeout_hit) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_enc_block_sched.sv
// tb/tb_conv_enc_block_sched.sv - directed bench for conv_enc_block_sched
// Models the meta/data FIFOs (non-show-ahead) and records encoder-side activity on the falling edge.
module tb_conv_enc_block_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        blk_ready = 1'b0;
  logic        meta_empty;
  logic [7:0]  meta_q = 8'h00;
  logic        meta_rdreq;
  logic        data_empty;
  logic [7:0]  data_q = 8'h00;
  logic        data_rdreq;
  logic        out_afull = 1'b0;
  logic        enc_start;
  logic        enc_size;
  logic [7:0]  enc_byte;
  logic        enc_byte_valid;
  logic        enc_done = 1'b0;
  logic        busy;
  logic [9:0]  byte_count;
  logic [15:0] blk_count;
  logic        err_timeout;
  logic [40:0] outs;

  conv_enc_block_sched dut (
    .clk(clk), .reset(rst), .blk_ready(blk_ready), .meta_empty(meta_empty),
    .meta_q(meta_q), .meta_rdreq(meta_rdreq), .data_empty(data_empty),
    .data_q(data_q), .data_rdreq(data_rdreq), .out_afull(out_afull),
    .enc_start(enc_start), .enc_size(enc_size), .enc_byte(enc_byte),
    .enc_byte_valid(enc_byte_valid), .enc_done(enc_done), .busy(busy),
    .byte_count(byte_count), .blk_count(blk_count), .err_timeout(err_timeout)
  );

  assign outs = {meta_rdreq, data_rdreq, enc_start, enc_size, enc_byte, enc_byte_valid,
                 busy, byte_count, blk_count, err_timeout};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // FIFO models
  logic [7:0] dmem [0:4095];
  logic [7:0] mmem [0:15];
  int dwr = 0, drd = 0, mwr = 0, mrd = 0;
  assign data_empty = (drd == dwr);
  assign meta_empty = (mrd == mwr);

  always @(posedge clk) begin
    if (data_rdreq && drd != dwr) begin
      data_q <= dmem[drd % 4096];
      drd    <= drd + 1;
    end
    if (meta_rdreq && mrd != mwr) begin
      meta_q <= mmem[mrd % 16];
      mrd    <= mrd + 1;
    end
  end

  // Monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap [0:4095];
  int cap_cyc [0:4095];
  int cap_n = 0, meta_n = 0, meta_cyc = 0, st_n = 0, st_cyc = 0;
  logic st_size [0:15];
  int afull_viol = 0, empty_viol = 0;

  always @(negedge clk) begin
    if (enc_byte_valid) begin
      cap[cap_n]     <= enc_byte;
      cap_cyc[cap_n] <= cyc;
      cap_n          <= cap_n + 1;
    end
    if (meta_rdreq) begin
      meta_n   <= meta_n + 1;
      meta_cyc <= cyc;
    end
    if (enc_start) begin
      st_size[st_n] <= enc_size;
      st_cyc        <= cyc;
      st_n          <= st_n + 1;
    end
    if (data_rdreq && out_afull)  afull_viol <= afull_viol + 1;
    if (data_rdreq && data_empty) empty_viol <= empty_viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      dmem[dwr % 4096] = 8'((seed + i) % 256);
      dwr = dwr + 1;
    end
  endtask

  task automatic push_block(input logic [7:0] meta, input int n, input int seed);
    mmem[mwr % 16] = meta;
    mwr = mwr + 1;
    push_bytes(n, seed);
  endtask

  task automatic wait_cap(input int n, input int budget, output bit ok);
    int i = 0;
    while (cap_n < n && i < budget) begin
      tick();
      i++;
    end
    ok = (cap_n >= n);
  endtask

  task automatic pulse_done();
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
  endtask

  function automatic int count_bad(input int cb, input int db, input int n);
    int b = 0;
    for (int i = 0; i < n; i++)
      if (cap[cb + i] !== dmem[(db + i) % 4096]) b++;
    return b;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (outs !== 41'd0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", outs); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (outs !== 41'd0) begin n_fail++; $display("FAIL idle_outputs got %h exp 0", outs); end
  endtask

  task automatic test_small_block();
    int cb = cap_n, mb = meta_n, sb = st_n, db;
    bit ok;
    push_block(8'h00, 0, 0);
    db = dwr;
    push_bytes(132, 0);
    blk_ready = 1'b1;
    wait_cap(cb + 132, 400, ok);
    blk_ready = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t1_bytes_arrived got %0d exp 132", cap_n - cb); end
    n_checks++;
    if (byte_count !== 10'd132) begin n_fail++; $display("FAIL t1_byte_count got %0d exp 132", byte_count); end
    n_checks++;
    if (meta_n - mb != 1) begin n_fail++; $display("FAIL t1_meta_pops got %0d exp 1", meta_n - mb); end
    n_checks++;
    if (st_n - sb != 1 || st_size[sb] !== 1'b0)
      begin n_fail++; $display("FAIL t1_start got n=%0d size=%b exp n=1 size=0", st_n - sb, st_size[sb]); end
    n_checks++;
    if (st_cyc - meta_cyc != 2) begin n_fail++; $display("FAIL t1_start_latency got %0d exp 2", st_cyc - meta_cyc); end
    n_checks++;
    if (cap_cyc[cb + 131] - cap_cyc[cb] != 131)
      begin n_fail++; $display("FAIL t1_contiguous got span %0d exp 131", cap_cyc[cb + 131] - cap_cyc[cb]); end
    n_checks++;
    if (count_bad(cb, db, 132) != 0) begin n_fail++; $display("FAIL t1_data got %0d bad bytes exp 0", count_bad(cb, db, 132)); end
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_waiting got %b exp 1", busy); end
    pulse_done();
    n_checks++;
    if (blk_count !== 16'd1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL t1_done got blk=%0d busy=%b exp blk=1 busy=0", blk_count, busy); end
  endtask

  task automatic test_throttle();
    int cb = cap_n, sb = st_n, av = afull_viol, db;
    bit ok;
    push_block(8'h01, 0, 0);
    db = dwr;
    push_bytes(768, 8'h40);
    blk_ready = 1'b1;
    wait_cap(cb + 100, 400, ok);
    out_afull = 1'b1;
    repeat (10) tick();
    out_afull = 1'b0;
    wait_cap(cb + 768, 1500, ok);
    blk_ready = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t2_bytes_arrived got %0d exp 768", cap_n - cb); end
    n_checks++;
    if (byte_count !== 10'd768) begin n_fail++; $display("FAIL t2_byte_count got %0d exp 768", byte_count); end
    n_checks++;
    if (afull_viol != av) begin n_fail++; $display("FAIL t2_rdreq_during_afull got %0d exp 0", afull_viol - av); end
    n_checks++;
    if (cap_cyc[cb + 767] - cap_cyc[cb] != 777)
      begin n_fail++; $display("FAIL t2_span got %0d exp 777", cap_cyc[cb + 767] - cap_cyc[cb]); end
    n_checks++;
    if (count_bad(cb, db, 768) != 0) begin n_fail++; $display("FAIL t2_data got %0d bad bytes exp 0", count_bad(cb, db, 768)); end
    n_checks++;
    if (st_size[sb] !== 1'b1) begin n_fail++; $display("FAIL t2_enc_size got %b exp 1", st_size[sb]); end
    pulse_done();
    n_checks++;
    if (blk_count !== 16'd2) begin n_fail++; $display("FAIL t2_blk_count got %0d exp 2", blk_count); end
  endtask

  task automatic test_underrun();
    int cb = cap_n, ev = empty_viol, db;
    bit ok;
    push_block(8'h00, 0, 0);
    db = dwr;
    push_bytes(50, 17);
    blk_ready = 1'b1;
    wait_cap(cb + 50, 200, ok);
    blk_ready = 1'b0;
    repeat (200) tick();
    n_checks++;
    if (cap_n - cb != 50 || byte_count !== 10'd50 || busy !== 1'b1)
      begin n_fail++; $display("FAIL t3_stall got cap=%0d bc=%0d busy=%b exp 50 50 1", cap_n - cb, byte_count, busy); end
    push_bytes(82, 17 + 50);
    wait_cap(cb + 132, 400, ok);
    n_checks++;
    if (!ok || byte_count !== 10'd132)
      begin n_fail++; $display("FAIL t3_resume got cap=%0d bc=%0d exp 132", cap_n - cb, byte_count); end
    n_checks++;
    if (count_bad(cb, db, 132) != 0) begin n_fail++; $display("FAIL t3_data got %0d bad bytes exp 0", count_bad(cb, db, 132)); end
    n_checks++;
    if (empty_viol != ev) begin n_fail++; $display("FAIL t3_rdreq_when_empty got %0d exp 0", empty_viol - ev); end
    pulse_done();
    n_checks++;
    if (err_timeout !== 1'b0 || blk_count !== 16'd3)
      begin n_fail++; $display("FAIL t3_done got err=%b blk=%0d exp 0 3", err_timeout, blk_count); end
  endtask

  task automatic test_timeout();
    int cb = cap_n, n = 0;
    bit ok;
    push_block(8'h00, 132, 99);
    blk_ready = 1'b1;
    wait_cap(cb + 132, 400, ok);
    blk_ready = 1'b0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    n_checks++;
    if (!ok || n != 4095) begin n_fail++; $display("FAIL t4_wait_cycles got %0d exp 4095", n); end
    n_checks++;
    if (err_timeout !== 1'b1 || blk_count !== 16'd3)
      begin n_fail++; $display("FAIL t4_flag got err=%b blk=%0d exp 1 3", err_timeout, blk_count); end
    cb = cap_n;
    push_block(8'h00, 132, 5);
    blk_ready = 1'b1;
    wait_cap(cb + 132, 400, ok);
    blk_ready = 1'b0;
    pulse_done();
    n_checks++;
    if (!ok || err_timeout !== 1'b1 || blk_count !== 16'd4)
      begin n_fail++; $display("FAIL t4_sticky got err=%b blk=%0d exp 1 4", err_timeout, blk_count); end
  endtask

  task automatic test_reset_mid_feed();
    int cb = cap_n, sb, db;
    bit ok;
    push_block(8'h01, 768, 3);
    blk_ready = 1'b1;
    wait_cap(cb + 60, 300, ok);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (!ok || outs !== 41'd0) begin n_fail++; $display("FAIL t5_async_reset got %h exp 0", outs); end
    blk_ready = 1'b0;
    tick();
    dwr = drd;
    mwr = mrd;
    rst = 1'b0;
    tick();
    cb = cap_n;
    sb = st_n;
    push_block(8'hFE, 0, 0);
    db = dwr;
    push_bytes(132, 200);
    blk_ready = 1'b1;
    wait_cap(cb + 132, 400, ok);
    blk_ready = 1'b0;
    n_checks++;
    if (!ok || byte_count !== 10'd132 || st_size[sb] !== 1'b0)
      begin n_fail++; $display("FAIL t5_fresh_block got cap=%0d size=%b exp 132 0", cap_n - cb, st_size[sb]); end
    n_checks++;
    if (count_bad(cb, db, 132) != 0) begin n_fail++; $display("FAIL t5_data got %0d bad bytes exp 0", count_bad(cb, db, 132)); end
    pulse_done();
    n_checks++;
    if (blk_count !== 16'd1 || err_timeout !== 1'b0)
      begin n_fail++; $display("FAIL t5_counts got blk=%0d err=%b exp 1 0", blk_count, err_timeout); end
  endtask

  task automatic test_back_to_back();
    int cb, sb, db;
    bit ok;
    do_reset();
    cb = cap_n;
    sb = st_n;
    db = dwr;
    push_block(8'h00, 132, 11);
    push_block(8'h01, 768, 11 + 132);
    blk_ready = 1'b1;
    wait_cap(cb + 40, 200, ok);
    pulse_done();
    n_checks++;
    if (blk_count !== 16'd0 || busy !== 1'b1)
      begin n_fail++; $display("FAIL t6_stray_done got blk=%0d busy=%b exp 0 1", blk_count, busy); end
    wait_cap(cb + 132, 300, ok);
    pulse_done();
    wait_cap(cb + 900, 1500, ok);
    blk_ready = 1'b0;
    pulse_done();
    n_checks++;
    if (!ok || st_n - sb != 2 || st_size[sb] !== 1'b0 || st_size[sb + 1] !== 1'b1)
      begin n_fail++; $display("FAIL t6_starts got n=%0d sizes=%b%b exp 2 01", st_n - sb, st_size[sb], st_size[sb + 1]); end
    n_checks++;
    if (count_bad(cb, db, 900) != 0) begin n_fail++; $display("FAIL t6_data got %0d bad bytes exp 0", count_bad(cb, db, 900)); end
    n_checks++;
    if (blk_count !== 16'd2 || busy !== 1'b0)
      begin n_fail++; $display("FAIL t6_blk_count got blk=%0d busy=%b exp 2 0", blk_count, busy); end
  endtask

  initial begin
    test_reset();
    test_small_block();
    test_throttle();
    test_underrun();
    test_timeout();
    test_reset_mid_feed();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
